// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative unsigned restoring divider, one quotient bit per clock
// Start/busy/done handshake; a new operand pair may be accepted in the result cycle.
module div_seq #(
  parameter int BITS = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [BITS-1:0] _A,
  input  logic [BITS-1:0] _B,
  output logic [BITS-1:0] Q_,
  output logic [BITS-1:0] R_,
  output logic            BUSY,
  output logic            DONE,
  output logic            DIV_ZERO
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // Dividend shifts out of the MSB while quotient bits shift into the LSB.
  logic [BITS-1:0] dvd_q;
  logic [BITS-1:0] dvs_q;
  // Restored partial remainder is always below the divisor, so its top bit is
  // implicitly zero and only BITS bits are kept.
  logic [BITS-1:0] p_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            last_step;
  logic [BITS:0]   p_shift;
  logic [BITS:0]   trial;
  logic            qbit;
  logic [BITS-1:0] p_step;
  logic [BITS-1:0] q_step;

  assign accept    = START && ((state == IDLE) || (state == FIN));
  assign last_step = (state == RUN) && (cnt_q == CW'(1));

  always_comb begin
    p_shift = {p_q, dvd_q[BITS-1]};
    trial   = p_shift - {1'b0, dvs_q};
    qbit    = ~trial[BITS];
    p_step  = qbit ? trial[BITS-1:0] : p_shift[BITS-1:0];
    q_step  = {dvd_q[BITS-2:0], qbit};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = FIN;
      FIN:     state_nxt = START ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dvd_q    <= '0;
      dvs_q    <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      Q_       <= '0;
      R_       <= '0;
      DIV_ZERO <= 1'b0;
    end else if (accept) begin
      dvd_q    <= _A;
      dvs_q    <= _B;
      p_q      <= '0;
      cnt_q    <= CW'(BITS);
      DIV_ZERO <= 1'b0;
    end else if (state == RUN) begin
      dvd_q <= q_step;
      p_q   <= p_step;
      cnt_q <= cnt_q - CW'(1);
      if (last_step) begin
        Q_       <= q_step;
        R_       <= p_step;
        DIV_ZERO <= (dvs_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq against an arithmetic model
module tb_div_seq;

  localparam int BITS = 4;

  logic            CLK;
  logic            RST;
  logic            START;
  logic [BITS-1:0] _A;
  logic [BITS-1:0] _B;
  logic [BITS-1:0] Q_;
  logic [BITS-1:0] R_;
  logic            BUSY;
  logic            DONE;
  logic            DIV_ZERO;

  int checks = 0;
  int errors = 0;

  div_seq #(.BITS(BITS)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    ._A       (_A),
    ._B       (_B),
    .Q_       (Q_),
    .R_       (R_),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .DIV_ZERO (DIV_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; divide by zero gives all ones and the dividend.
  task automatic model(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q  = (1 << BITS) - 1;
      r  = a;
      dz = 1;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 0;
    end
  endtask

  // Called at #1 after the accept edge with START already dropped (or held by caller).
  task automatic finish_op(input string tag, input int a, input int b, input bit drain);
    int n;
    int busy_cnt;
    int q, r, dz;
    model(a, b, q, r, dz);
    chk({tag, "_busy_at_accept"}, int'(BUSY), 1);
    n        = 0;
    busy_cnt = 1;
    while (!DONE && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
      if (BUSY) busy_cnt++;
    end
    chk({tag, "_latency"}, n, BITS);
    chk({tag, "_busy_cycles"}, busy_cnt, BITS);
    chk({tag, "_q"}, int'(Q_), q);
    chk({tag, "_r"}, int'(R_), r);
    chk({tag, "_dz"}, int'(DIV_ZERO), dz);
    if (dz == 0) begin
      chk({tag, "_inv"}, int'(Q_) * b + int'(R_), a);
      chk({tag, "_r_lt_b"}, int'(int'(R_) < b), 1);
    end
    if (drain) begin
      @(posedge CLK);
      #1;
      chk({tag, "_done_pulse"}, int'(DONE), 0);
      chk({tag, "_idle_busy"}, int'(BUSY), 0);
    end
  endtask

  task automatic op(input string tag, input int a, input int b);
    @(negedge CLK);
    START = 1'b1;
    _A    = BITS'(a);
    _B    = BITS'(b);
    @(posedge CLK);
    #1;
    START = 1'b0;
    _A    = BITS'($urandom);
    _B    = BITS'($urandom);
    finish_op(tag, a, b, 1'b1);
  endtask

  initial begin
    int n;
    int dcount;
    int dedge;
    int dq, dr;

    RST   = 1'b1;
    START = 1'b0;
    _A    = '0;
    _B    = '0;
    #12;
    chk("rst_q", int'(Q_), 0);
    chk("rst_r", int'(R_), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_dz", int'(DIV_ZERO), 0);
    @(negedge CLK);
    RST = 1'b0;

    op("d13_3", 13, 3);
    op("d15_1", 15, 1);
    op("d3_7", 3, 7);
    op("d0_5", 0, 5);
    op("d7_0", 7, 0);
    op("d9_2", 9, 2);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op("sweep", a, b);
      end
    end

    for (int i = 0; i < 20; i++) begin
      op("rand", int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
    end

    // START pulsed during RUN must be ignored.
    @(negedge CLK);
    START = 1'b1;
    _A    = 4'd13;
    _B    = 4'd3;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    _A    = 4'd9;
    _B    = 4'd4;
    @(posedge CLK);
    #1;
    START = 1'b0;
    dcount = 0;
    dedge  = -1;
    dq     = -1;
    dr     = -1;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) begin
        dcount++;
        if (dedge < 0) begin
          dedge = i;
          dq    = int'(Q_);
          dr    = int'(R_);
        end
      end
    end
    chk("busy_start_done_count", dcount, 1);
    chk("busy_start_done_edge", dedge, 2);
    chk("busy_start_q", dq, 4);
    chk("busy_start_r", dr, 1);

    // START held high: second accept lands in the FIN cycle.
    @(negedge CLK);
    START = 1'b1;
    _A    = 4'd12;
    _B    = 4'd5;
    @(posedge CLK);
    #1;
    _A = 4'd14;
    _B = 4'd3;
    n  = 0;
    while (!DONE && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("b2b_first_latency", n, BITS);
    chk("b2b_first_q", int'(Q_), 2);
    chk("b2b_first_r", int'(R_), 2);
    @(posedge CLK);
    #1;
    START = 1'b0;
    chk("b2b_fin_accept_done", int'(DONE), 0);
    n = 1;
    while (!DONE && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("b2b_done_spacing", n, BITS + 1);
    chk("b2b_second_q", int'(Q_), 4);
    chk("b2b_second_r", int'(R_), 2);
    @(posedge CLK);
    #1;
    chk("b2b_done_pulse", int'(DONE), 0);

    // Asynchronous reset in the second RUN cycle.
    @(negedge CLK);
    START = 1'b1;
    _A    = 4'd13;
    _B    = 4'd3;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_q", int'(Q_), 0);
    chk("arst_r", int'(R_), 0);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_done", int'(DONE), 0);
    chk("arst_dz", int'(DIV_ZERO), 0);
    START = 1'b1;
    _A    = 4'd10;
    _B    = 4'd3;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      if (DONE) dcount++;
    end
    chk("arst_no_done", dcount, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    START = 1'b0;
    finish_op("post_rst_10_3", 10, 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
